// File: rtl/alt_vipcts_stream_input_fifo.sv
// Avalon-ST input stage for VIP cores.
// Takes a ready-latency-1 stream (registered din_ready) and presents a
// ready-latency-0 internal stream (int_valid/int_ready) from a small credit FIFO.
// Carries sop/eop/empty through, tags each packet with its type nibble, and
// flags sop/eop protocol errors.
//
// Handshake semantics:
//   din side : din_ready high in cycle N permits din_valid in cycle N+1; a beat is
//              written when din_valid is high and din_ready was high the cycle before.
//   int side : a beat transfers on any edge where int_valid & int_ready are both high;
//              int_valid never depends on int_ready.
module alt_vipcts_stream_input_fifo #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int DEPTH            = 4,
  parameter int EMPTY_WIDTH      = 2,
  localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   din_ready,
  input  logic                   din_valid,
  input  logic [DATA_WIDTH-1:0]  din_data,
  input  logic                   din_sop,
  input  logic                   din_eop,
  input  logic [EMPTY_WIDTH-1:0] din_empty,
  input  logic                   int_ready,
  output logic                   int_valid,
  output logic [DATA_WIDTH-1:0]  int_data,
  output logic                   int_sop,
  output logic                   int_eop,
  output logic [EMPTY_WIDTH-1:0] int_empty,
  output logic [3:0]             int_pkt_type,
  output logic                   int_pkt_video,
  output logic                   err_sop,
  output logic                   err_eop
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int SUM_W   = CNT_W + 2;
  localparam int ENTRY_W = DATA_WIDTH + EMPTY_WIDTH + 3;

  // Entry layout: {tag, sop, eop, empty, data}
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               head_tag;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [SUM_W-1:0] ready_sum;
  logic             ready_next;
  logic             din_ready_q;
  logic             in_packet;
  logic             type_armed;
  logic             wr;
  logic             rd;
  logic             wr_tag;

  assign wr        = din_valid & din_ready_q;
  assign int_valid = (count != '0);
  assign rd        = int_valid & int_ready;

  assign head = mem[rd_ptr];
  assign {head_tag, int_sop, int_eop, int_empty, int_data} = head;

  // The beat carrying the packet type: a single-beat packet tags itself,
  // otherwise the first write after an armed sop is tagged.
  assign wr_tag = din_sop ? din_eop : type_armed;

  // Occupancy after this edge.
  always_comb begin
    count_next = count;
    if (wr && !rd)      count_next = count + 1'b1;
    else if (!wr && rd) count_next = count - 1'b1;
  end

  // Credit check: room for the beat din_ready already permits next cycle plus
  // one more if din_ready stays high. Reads are ignored, so any upstream is safe.
  assign ready_sum  = SUM_W'(count_next) + SUM_W'(din_ready) + SUM_W'(1);
  assign ready_next = (ready_sum <= SUM_W'(DEPTH));

  // Pointer, occupancy and ready registers; pointers wrap explicitly at DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      din_ready   <= 1'b0;
      din_ready_q <= 1'b0;
    end else begin
      count       <= count_next;
      din_ready   <= ready_next;
      din_ready_q <= din_ready;
      if (wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Storage; cleared on reset so the head reads as zero until the first write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= {wr_tag, din_sop, din_eop, din_empty, din_data};
    end
  end

  // Write-side packet tracking and registered protocol-error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_packet  <= 1'b0;
      type_armed <= 1'b0;
      err_sop    <= 1'b0;
      err_eop    <= 1'b0;
    end else begin
      err_sop <= wr & din_sop & in_packet;
      err_eop <= wr & din_eop & ~in_packet & ~din_sop;
      if (wr) begin
        if (din_sop) begin
          in_packet  <= ~din_eop;
          type_armed <= ~din_eop;
        end else begin
          type_armed <= 1'b0;
          if (din_eop) in_packet <= 1'b0;
        end
      end
    end
  end

  // Packet type follows the tagged beat as it leaves the head; held until the next tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_pkt_type  <= 4'h0;
      int_pkt_video <= 1'b1;
    end else if (rd && head_tag) begin
      int_pkt_type  <= int_data[3:0];
      int_pkt_video <= (int_data[3:0] == 4'h0);
    end
  end

endmodule

// File: tb/tb_alt_vipcts_stream_input_fifo.sv
// Directed bench for alt_vipcts_stream_input_fifo (DEPTH=4, 3x8-bit symbols).
module tb_alt_vipcts_stream_input_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 24;
  localparam int W     = DW + 4;   // {data, sop, eop, empty}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_ready;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din_data  = '0;
  logic          din_sop   = 1'b0;
  logic          din_eop   = 1'b0;
  logic [1:0]    din_empty = '0;
  logic          int_ready = 1'b0;
  logic          int_valid;
  logic [DW-1:0] int_data;
  logic          int_sop;
  logic          int_eop;
  logic [1:0]    int_empty;
  logic [3:0]    int_pkt_type;
  logic          int_pkt_video;
  logic          err_sop;
  logic          err_eop;

  alt_vipcts_stream_input_fifo #(
    .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .DEPTH(DEPTH), .EMPTY_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .din_ready(din_ready), .din_valid(din_valid), .din_data(din_data),
    .din_sop(din_sop), .din_eop(din_eop), .din_empty(din_empty),
    .int_ready(int_ready), .int_valid(int_valid), .int_data(int_data),
    .int_sop(int_sop), .int_eop(int_eop), .int_empty(int_empty),
    .int_pkt_type(int_pkt_type), .int_pkt_video(int_pkt_video),
    .err_sop(err_sop), .err_eop(err_eop)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  prev_rdy = 1'b0;   // din_ready seen in the previous cycle
  bit  last_sent;
  bit  err_sop_seen;
  bit  err_eop_seen;
  int  occ = 0;
  int  max_occ = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One cycle: sample outputs at the negedge, score any transfer, then drive inputs.
  task automatic step(input bit vld, input bit rdy, input logic [DW-1:0] d,
                      input bit s, input bit e, input logic [1:0] em);
    logic [W-1:0] head;
    @(negedge clk);
    err_sop_seen = err_sop;
    err_eop_seen = err_eop;
    int_ready = rdy;
    if (int_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'(int_valid), 32'd0);
      end else begin
        head = exp_q.pop_front();
        check("data_order", 32'({int_data, int_sop, int_eop, int_empty}), 32'(head));
        occ--;
      end
    end
    last_sent = vld && prev_rdy;
    din_valid = last_sent;
    din_data  = d;
    din_sop   = s;
    din_eop   = e;
    din_empty = em;
    if (last_sent) begin
      exp_q.push_back({d, s, e, em});
      occ++;
      if (occ > max_occ) max_occ = occ;
    end
    prev_rdy = din_ready;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, rdy, '0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      idle(1'b1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(1'b1);
    check("idle_int_valid", 32'(int_valid), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    int_ready = 1'b0;
    prev_rdy = 1'b0;
    exp_q.delete();
    occ = 0;
    repeat (3) @(negedge clk);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_int_valid", 32'(int_valid), 32'd0);
    check("rst_int_head", 32'({int_data, int_sop, int_eop, int_empty}), 32'd0);
    check("rst_pkt_type", 32'(int_pkt_type), 32'd0);
    check("rst_pkt_video", 32'(int_pkt_video), 32'd1);
    check("rst_err", 32'({err_sop, err_eop}), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int stalls;
    int bubbles;
    int sent_cnt;

    // Reset state
    apply_reset();

    // Back-to-back stream, 1-cycle latency, no bubbles
    idle(1'b1);
    check("ready_first_edge", 32'(din_ready), 32'd1);
    stalls = 0;
    bubbles = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, DW'(i * 32'h010203 + 7), 1'b0, 1'b0, 2'd0);
      if (!last_sent) stalls++;
      if (i > 0 && !int_valid) bubbles++;
      if (i > 0 && exp_q.size() != 1) bubbles++;
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_bubbles", 32'(bubbles), 32'd0);
    drain();

    // Downstream stalled: exactly DEPTH beats stored
    sent_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, DW'(32'h500000 + i), 1'b0, 1'b0, 2'd0);
      if (last_sent) sent_cnt++;
    end
    check("stored_beats", 32'(sent_cnt), 32'(DEPTH));
    check("ready_low_full", 32'(din_ready), 32'd0);
    check("full_int_valid", 32'(int_valid), 32'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, DW'(32'h600000 + i), 1'b0, 1'b0, 2'd0);
    drain();

    // Random valid 50% / ready 30%
    max_occ = 0;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
           DW'($urandom), 1'b0, 1'b0, 2'($urandom_range(0, 2)));
    end
    drain();
    check("max_occupancy", 32'(max_occ <= DEPTH), 32'd1);

    // Packet type tagging
    step(1'b1, 1'b1, 24'h000001, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 24'hABC12F, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 24'h000033, 1'b0, 1'b1, 2'd1);
    drain();
    check("pkt_type_f", 32'(int_pkt_type), 32'hF);
    check("pkt_video_f", 32'(int_pkt_video), 32'd0);
    step(1'b1, 1'b1, 24'h000007, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 24'h123450, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 24'h000044, 1'b0, 1'b1, 2'd2);
    drain();
    check("pkt_type_0", 32'(int_pkt_type), 32'h0);
    check("pkt_video_0", 32'(int_pkt_video), 32'd1);
    step(1'b1, 1'b1, 24'h00000A, 1'b1, 1'b1, 2'd0);
    drain();
    check("pkt_type_single", 32'(int_pkt_type), 32'hA);

    // Protocol errors
    step(1'b1, 1'b1, 24'h000011, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 24'h000022, 1'b1, 1'b0, 2'd0);
    check("err_sop_first", 32'(err_sop_seen), 32'd0);
    step(1'b1, 1'b1, 24'h000033, 1'b0, 1'b1, 2'd0);
    check("err_sop_pulse", 32'(err_sop_seen), 32'd1);
    step(1'b1, 1'b1, 24'h000044, 1'b0, 1'b1, 2'd0);
    check("err_sop_clear", 32'(err_sop_seen), 32'd0);
    check("err_eop_legal", 32'(err_eop_seen), 32'd0);
    idle(1'b1);
    check("err_eop_pulse", 32'(err_eop_seen), 32'd1);
    idle(1'b1);
    check("err_eop_clear", 32'(err_eop_seen), 32'd0);
    drain();
    check("pkt_type_err", 32'(int_pkt_type), 32'h3);

    // Reset with 3 beats buffered
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(32'h700000 + i), 1'b0, 1'b0, 2'd0);
    idle(1'b0);
    check("pre_rst_valid", 32'(int_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(int_valid), 32'd0);
    check("async_rst_ready", 32'(din_ready), 32'd0);
    apply_reset();
    idle(1'b1);
    check("restart_ready", 32'(din_ready), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, DW'(32'h800000 + i), 1'b0, 1'b0, 2'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
